gpio_bus_arbiter: RTL and testbench

- Shares one memory-mapped 8-bit peripheral port between two requesters (m0 = CPU load/store unit, m1 = DMA/debug master).
- The peripheral side uses the standard level read/write strobes with registered ready_r/ready_w.
- The block arbitrates round-robin, issues exactly one single-cycle strobe per transaction and waits for ready.
- It then returns data plus a one-cycle ack to the granted requester, with a timeout for unresponsive peripherals.

---
 rtl/gpio_bus_pkg.sv | 18 +
 rtl/rr_arb2.sv | 22 ++
 rtl/gpio_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the two-master peripheral port arbiter.
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic other_master(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the master that did not win last time wins.
module rr_arb2
  import gpio_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = M0;
    case (req)
      2'b01:   grant = M0;
      2'b10:   grant = M1;
      2'b11:   grant = other_master(last_grant);
      default: grant = M0;
    endcase
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Shares one 8-bit peripheral port between two requesters: round-robin grant,
// single-cycle strobe, wait for the matching ready or time out, then a one-cycle ack.
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int unsigned size_addr = 4,
  parameter int unsigned timeout   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [size_addr-1:0] m0_addr,
  input  logic [7:0]           m0_wdata,
  output logic                 m0_ack,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [size_addr-1:0] m1_addr,
  input  logic [7:0]           m1_wdata,
  output logic                 m1_ack,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 per_read,
  output logic                 per_write,
  output logic [size_addr-1:0] per_address,
  output logic [7:0]           per_data_in,
  input  logic [7:0]           per_data_out,
  input  logic                 per_ready_r,
  input  logic                 per_ready_w
);

  // Last WAIT-cycle count value before the transaction is declared dead.
  localparam logic [7:0] TimeoutLast = 8'(timeout - 1);

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic                 we_q, we_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 m0_ack_q, m0_ack_d;
  logic                 m1_ack_q, m1_ack_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 per_read_q, per_read_d;
  logic                 per_write_q, per_write_d;
  logic [size_addr-1:0] per_address_q, per_address_d;
  logic [7:0]           per_data_in_q, per_data_in_d;

  logic                 arb_grant;
  logic                 arb_valid;
  logic                 sel_we;
  logic [size_addr-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic                 complete;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    sel_we    = (arb_grant == M1) ? m1_we    : m0_we;
    sel_addr  = (arb_grant == M1) ? m1_addr  : m0_addr;
    sel_wdata = (arb_grant == M1) ? m1_wdata : m0_wdata;
  end

  // Only the ready that matches the latched direction counts.
  assign complete = we_q ? per_ready_w : per_ready_r;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    per_address_d = per_address_q;
    per_data_in_d = per_data_in_q;
    per_read_d    = 1'b0;
    per_write_d   = 1'b0;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (arb_valid) begin
          state_d       = ISSUE;
          grant_d       = arb_grant;
          last_grant_d  = arb_grant;
          we_d          = sel_we;
          per_address_d = sel_addr;
          per_data_in_d = sel_wdata;
          per_read_d    = ~sel_we;
          per_write_d   = sel_we;
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (complete) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = per_data_out;
          end
          m0_ack_d = (grant_q == M0);
          m1_ack_d = (grant_q == M1);
        end else if (cnt_q == TimeoutLast) begin
          state_d  = DONE;
          rdata_d  = 8'd0;
          err_d    = 1'b1;
          m0_ack_d = (grant_q == M0);
          m1_ack_d = (grant_q == M1);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= M1;
      grant_q       <= M0;
      we_q          <= 1'b0;
      cnt_q         <= 8'd0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      rdata_q       <= 8'd0;
      err_q         <= 1'b0;
      per_read_q    <= 1'b0;
      per_write_q   <= 1'b0;
      per_address_q <= '0;
      per_data_in_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      per_read_q    <= per_read_d;
      per_write_q   <= per_write_d;
      per_address_q <= per_address_d;
      per_data_in_q <= per_data_in_d;
    end
  end

  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign per_read    = per_read_q;
  assign per_write   = per_write_q;
  assign per_address = per_address_q;
  assign per_data_in = per_data_in_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: a small peripheral model plus an ack scoreboard.
module tb_gpio_bus_arbiter;

  localparam int unsigned SizeAddr = 4;
  localparam int unsigned Timeout  = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic                m0_req, m0_we, m1_req, m1_we;
  logic [SizeAddr-1:0] m0_addr, m1_addr;
  logic [7:0]          m0_wdata, m1_wdata;
  logic                m0_ack, m1_ack, err;
  logic [7:0]          rdata;
  logic                per_read, per_write;
  logic [SizeAddr-1:0] per_address;
  logic [7:0]          per_data_in, per_data_out;
  logic                per_ready_r, per_ready_w;

  gpio_bus_arbiter #(
    .size_addr (SizeAddr),
    .timeout   (Timeout)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_ack       (m0_ack),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_ack       (m1_ack),
    .rdata        (rdata),
    .err          (err),
    .per_read     (per_read),
    .per_write    (per_write),
    .per_address  (per_address),
    .per_data_in  (per_data_in),
    .per_data_out (per_data_out),
    .per_ready_r  (per_ready_r),
    .per_ready_w  (per_ready_w)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Standard peripheral answers one cycle after a strobe; manual mode lets steps drive ready.
  logic       auto_mode = 1'b1;
  logic [7:0] auto_data = 8'h00;
  logic       auto_rr = 1'b0, auto_rw = 1'b0;
  logic [7:0] auto_do = 8'h00;
  logic       man_rr = 1'b0, man_rw = 1'b0;
  logic [7:0] man_do = 8'h00;

  always @(posedge clk) begin
    auto_rr <= per_read;
    auto_rw <= per_write;
    if (per_read) auto_do <= auto_data;
  end

  assign per_ready_r  = auto_mode ? auto_rr : man_rr;
  assign per_ready_w  = auto_mode ? auto_rw : man_rw;
  assign per_data_out = auto_mode ? auto_do : man_do;

  int rd_strobes = 0;
  int wr_strobes = 0;
  int overlaps   = 0;

  always @(negedge clk) begin
    if (per_read)  rd_strobes <= rd_strobes + 1;
    if (per_write) wr_strobes <= wr_strobes + 1;
    if ((per_read && per_write) || (m0_ack && m1_ack)) overlaps <= overlaps + 1;
  end

  typedef struct packed {
    logic       master;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for any ack within budget cycles and scores it against the queue head.
  task automatic wait_ack(input string tag, input int budget, output int ack_cyc);
    bit   got;
    int   n;
    exp_t e;
    got = 1'b0;
    n   = 0;
    ack_cyc = -1;
    while (!got && n < budget) begin
      tick();
      n++;
      if (m0_ack || m1_ack) got = 1'b1;
    end
    chk({tag, "_ack_seen"}, 32'(got), 1);
    if (got) begin
      ack_cyc = cyc;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_ack_master"}, 32'(m1_ack), 32'(e.master));
        chk({tag, "_ack_onehot"}, 32'(m0_ack & m1_ack), 0);
        chk({tag, "_rdata"}, 32'(rdata), 32'(e.rdata));
        chk({tag, "_err"}, 32'(err), 32'(e.err));
      end
    end
  endtask

  int s_cyc, a_cyc, prev;
  int base_rd, base_wr;

  initial begin
    reset = 1'b1;
    {m0_req, m0_we, m1_req, m1_we} = 4'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = 8'h00; m1_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_per_read", 32'(per_read), 0);
    chk("rst_per_write", 32'(per_write), 0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    @(negedge clk) reset = 1'b0;

    // m0 read of address 3.
    base_rd = rd_strobes;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd3; auto_data = 8'hA5;
    sb.push_back('{master: 1'b0, rdata: 8'hA5, err: 1'b0});
    tick();
    s_cyc = cyc;
    chk("rd_per_read", 32'(per_read), 1);
    chk("rd_per_write", 32'(per_write), 0);
    chk("rd_per_address", 32'(per_address), 3);
    wait_ack("rd", 8, a_cyc);
    chk("rd_latency", 32'(a_cyc - s_cyc), 2);
    @(negedge clk) m0_req = 1'b0;
    chk("rd_strobe_count", 32'(rd_strobes - base_rd), 1);
    tick();
    chk("rd_ack_single", 32'(m0_ack), 0);

    // m1 write of 3C to address 7; rdata keeps the previous read value.
    base_rd = rd_strobes;
    base_wr = wr_strobes;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'd7; m1_wdata = 8'h3C;
    sb.push_back('{master: 1'b1, rdata: 8'hA5, err: 1'b0});
    tick();
    s_cyc = cyc;
    chk("wr_per_write", 32'(per_write), 1);
    chk("wr_per_data_in", 32'(per_data_in), 32'h3C);
    chk("wr_per_address", 32'(per_address), 7);
    tick();
    chk("wr_strobe_drop", 32'(per_write), 0);
    chk("wr_addr_stable", 32'(per_address), 7);
    wait_ack("wr", 8, a_cyc);
    chk("wr_latency", 32'(a_cyc - s_cyc), 2);
    chk("wr_data_stable", 32'(per_data_in), 32'h3C);
    @(negedge clk) m1_req = 1'b0;
    chk("wr_rd_strobes", 32'(rd_strobes - base_rd), 0);
    chk("wr_wr_strobes", 32'(wr_strobes - base_wr), 1);

    // Continuous tie after reset: m0, m1, m0, m1, one every 4 cycles.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd2;
    auto_data = 8'h5A;
    for (int i = 0; i < 4; i++) sb.push_back('{master: 1'(i % 2), rdata: 8'h5A, err: 1'b0});
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack("tie", 10, a_cyc);
      if (i > 0) chk("tie_interval", 32'(a_cyc - prev), 4);
      prev = a_cyc;
    end
    @(negedge clk) begin m0_req = 1'b0; m1_req = 1'b0; end

    // Silent peripheral: error ack after Timeout WAIT cycles.
    @(negedge clk);
    auto_mode = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd5;
    sb.push_back('{master: 1'b0, rdata: 8'h00, err: 1'b1});
    tick();
    s_cyc = cyc;
    chk("to_per_read", 32'(per_read), 1);
    wait_ack("to", 30, a_cyc);
    chk("to_latency", 32'(a_cyc - s_cyc), Timeout + 1);
    @(negedge clk) m0_req = 1'b0;
    tick();
    chk("to_err_clear", 32'(err), 0);

    // Normal transaction right after a timeout.
    @(negedge clk);
    auto_mode = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd2; auto_data = 8'hC3;
    sb.push_back('{master: 1'b1, rdata: 8'hC3, err: 1'b0});
    tick();
    s_cyc = cyc;
    wait_ack("after_to", 8, a_cyc);
    chk("after_to_latency", 32'(a_cyc - s_cyc), 2);
    @(negedge clk) m1_req = 1'b0;

    // Spurious write-ready during a read is ignored.
    @(negedge clk);
    auto_mode = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd9;
    sb.push_back('{master: 1'b0, rdata: 8'h77, err: 1'b0});
    tick();
    tick();
    @(negedge clk) man_rw = 1'b1;
    tick();
    chk("sp_no_ack", 32'({m0_ack, m1_ack}), 0);
    @(negedge clk) begin man_rw = 1'b0; man_rr = 1'b1; man_do = 8'h77; end
    wait_ack("sp", 3, a_cyc);

    // Reset while ack is high drops it without a clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_ack_drop", 32'(m0_ack), 0);
    chk("rst_rdata_drop", 32'(rdata), 0);
    @(negedge clk) begin man_rr = 1'b0; m0_req = 1'b0; auto_mode = 1'b1; end
    @(negedge clk) reset = 1'b0;

    // Reset during the strobe cycle abandons the transaction.
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd4;
    tick();
    chk("rst_pre_strobe", 32'(per_read), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_strobe_drop", 32'(per_read), 0);
    chk("rst_addr_drop", 32'(per_address), 0);
    @(negedge clk) m1_req = 1'b0;
    @(negedge clk) reset = 1'b0;
    tick();
    chk("rst_abandoned", 32'({m0_ack, m1_ack, per_read}), 0);

    // First tie after reset goes to m0.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd6;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd8;
    auto_data = 8'h99;
    sb.push_back('{master: 1'b0, rdata: 8'h99, err: 1'b0});
    sb.push_back('{master: 1'b1, rdata: 8'h99, err: 1'b0});
    wait_ack("post_rst_tie0", 10, a_cyc);
    wait_ack("post_rst_tie1", 10, a_cyc);
    @(negedge clk) begin m0_req = 1'b0; m1_req = 1'b0; end
    tick();

    chk("no_overlaps", 32'(overlaps), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
